uart_bus_bridge: RTL and testbench
==================================

// Module: uart_bus_bridge
// PURPOSE
//  Serial debug bus initiator: receives 8N1 command frames on rxd, performs single-byte reads/writes
//  on the 16-bit CPU-style bus (address/dout/din/read) and answers on txd. Drives the same responders
//  the CPU drives (SRAM, UART, GPIO, timer); the top level muxes bus ownership via bus_req/bus_gnt.
// PARAMETERS
//  CLKS_PER_BIT  18  clk cycles per serial bit (2.08 MHz / 115200); legal range >= 4
//  READ_WAIT     1   extra cycles address is held before din is sampled (sync SRAM needs 1)
// PORTS
//  clk      in   1   system clock; all logic on posedge
//  rst      in   1   synchronous reset, active-low (0 = reset)
//  rxd      in   1   serial in, idle high; 2-flop synchronised internally
//  txd      out  1   serial out, idle high
//  bus_req  out  1   request bus ownership
//  bus_gnt  in   1   top level has switched bus mux to this block
//  address  out  16  bus address
//  dout     out  8   write data
//  din      in   8   read data from selected responder
//  read     out  1   1 = read / idle, 0 = write strobe
//  busy     out  1   command FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0 at posedge): txd=1, bus_req=0, read=1, address=0, dout=0, busy=0; RX/TX/command FSMs
//   to idle; any frame in flight is truncated (txd forced high that cycle).
//  RX: falling edge on synced rxd starts frame; start bit re-checked at CLKS_PER_BIT/2 (high -> glitch,
//   back to idle); data LSB first, sampled mid-bit; stop bit sampled mid-bit; stop=0 -> byte discarded.
//   rx_valid pulses 1 cycle at stop-bit sample.
//  TX: 1 start, 8 data LSB first, 1 stop, each exactly CLKS_PER_BIT cycles; tx_done after stop bit.
//  Command FSM: IDLE -> (byte 'W'=0x57 | 'R'=0x52) ADDR_H -> ADDR_L -> [W: DATA] -> REQ -> BUS -> REPLY -> IDLE.
//   IDLE with any other byte -> REPLY with 0x3F ('?').
//   Bytes arriving in REQ/BUS/REPLY are dropped (no queue); host must wait for reply.
//  REQ: bus_req=1; waits indefinitely for bus_gnt=1 (sampled only in REQ). bus_gnt must stay high
//   until bus_req falls; not re-checked.
//  BUS write: address/dout valid, read=0 for exactly 1 cycle, then read=1, bus_req=0 next cycle;
//   reply 0x2E ('.').
//  BUS read: read=1, address held READ_WAIT+1 cycles; din captured on last cycle; bus_req=0 next
//   cycle; reply = captured byte.
//  address/dout hold last value after transaction (not cleared). busy=1 from first command byte
//   to end of reply stop bit.
//  Address wrap: 16-bit, 0xFFFF + 1 = 0x0000 (auto-increment only).
// CONFIGURATION
//  UART_BRIDGE_AUTOINC_EN defined: address register post-increments after every bus access;
//   extra commands 'n'=0x6E (read at current address, no address bytes) and 'm'=0x6D + 1 data byte
//   (write at current address); both reply as R/W and increment.
//  Not defined: no increment; 0x6E/0x6D treated as unknown -> reply 0x3F.
// TESTING
//  1 rst=0 for 3 cycles mid TX frame -> txd=1, bus_req=0, read=1, busy=0 on next posedge.
//  2 send 57 E6 D0 A5, gnt tied 1 -> exactly one cycle read=0, address=E6D0, dout=A5; reply 2E.
//  3 send 52 01 23, din model returns 3C one cycle after address -> txd frame 3C; bus_req low after.
//  4 send 52 00 10 with bus_gnt=0 for 200 cycles -> bus_req held 1, no bus activity, no reply;
//    then gnt=1 -> read completes and reply sent.
//  5 send 0x41 -> reply 3F; send byte with stop bit 0 -> no reply, FSM stays IDLE; 1/4-bit rxd glitch ignored.
//  6 AUTOINC_EN: 57 FF FF 11 then 6D 22 -> writes FFFF=11, 0000=22; 6E reads 0001; without macro 6E -> 3F.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: 8N1 serial debug bus initiator; define UART_BRIDGE_AUTOINC_EN for address auto-increment and 'n'/'m' commands
module uart_bus_bridge #(
  parameter int CLKS_PER_BIT = 18,
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] address,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic        read,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(READ_WAIT + 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_REQ, S_BUS, S_REPLY} st_t;
  rx_t rx_st;
  st_t state;
  logic rx_q1, rx_q2, rx_q3, rx_valid;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh, tx_data;
  logic [3:0] tx_bit;
  logic [8:0] tx_sh;
  logic tx_on, tx_go, tx_done, is_wr;
  logic [WW-1:0] wcnt;
  assign busy = state != S_IDLE;
  // rx_q3 lags rx_q2 by one cycle so a high-to-low step marks the start edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      {rx_q1, rx_q2, rx_q3} <= 3'b111;
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_valid <= 1'b0;
    end else begin
      {rx_q1, rx_q2, rx_q3} <= {rxd, rx_q1, rx_q2};
      rx_valid <= 1'b0;
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_st)
        R_IDLE: begin
          rx_cnt <= '0;
          if (rx_q3 && !rx_q2) rx_st <= R_START;
        end
        R_START: if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st <= rx_q2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (rx_cnt == FULL) begin
          rx_cnt <= '0;
          rx_sh <= {rx_q2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= R_STOP;
        end
        R_STOP: if (rx_cnt == FULL) begin
          rx_valid <= rx_q2;
          rx_st <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      txd <= 1'b1;
      tx_on <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_on && tx_go) begin
        tx_on <= 1'b1;
        tx_sh <= {1'b1, tx_data};
        txd <= 1'b0;
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_on) begin
        tx_cnt <= tx_cnt == FULL ? '0 : tx_cnt + 1'b1;
        if (tx_cnt == FULL) begin
          if (tx_bit == 4'd9) begin
            tx_on <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            txd <= tx_sh[0];
            tx_sh <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      bus_req <= 1'b0;
      read <= 1'b1;
      address <= '0;
      dout <= '0;
      tx_go <= 1'b0;
      tx_data <= '0;
      is_wr <= 1'b0;
      wcnt <= '0;
    end else begin
      tx_go <= 1'b0;
      case (state)
        S_IDLE: if (rx_valid) begin
          if (rx_sh == 8'h57 || rx_sh == 8'h52) begin
            is_wr <= rx_sh == 8'h57;
            state <= S_ADDR_H;
          end
`ifdef UART_BRIDGE_AUTOINC_EN
          else if (rx_sh == 8'h6E) begin
            is_wr <= 1'b0;
            bus_req <= 1'b1;
            state <= S_REQ;
          end else if (rx_sh == 8'h6D) begin
            is_wr <= 1'b1;
            state <= S_DATA;
          end
`endif
          else begin
            tx_data <= 8'h3F;
            tx_go <= 1'b1;
            state <= S_REPLY;
          end
        end
        S_ADDR_H: if (rx_valid) begin
          address[15:8] <= rx_sh;
          state <= S_ADDR_L;
        end
        S_ADDR_L: if (rx_valid) begin
          address[7:0] <= rx_sh;
          bus_req <= !is_wr;
          state <= is_wr ? S_DATA : S_REQ;
        end
        S_DATA: if (rx_valid) begin
          dout <= rx_sh;
          bus_req <= 1'b1;
          state <= S_REQ;
        end
        S_REQ: if (bus_gnt) begin
          read <= !is_wr;
          wcnt <= '0;
          state <= S_BUS;
        end
        // write strobe lasts this single cycle; reads dwell READ_WAIT+1 cycles
        S_BUS: if (is_wr || wcnt == WW'(READ_WAIT)) begin
          read <= 1'b1;
          bus_req <= 1'b0;
          tx_data <= is_wr ? 8'h2E : din;
          tx_go <= 1'b1;
          state <= S_REPLY;
`ifdef UART_BRIDGE_AUTOINC_EN
          address <= address + 16'd1;
`endif
        end else wcnt <= wcnt + 1'b1;
        S_REPLY: if (tx_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed checks of the serial bus bridge
module tb_uart_bus_bridge;
  localparam int CPB = 18;
  logic clk = 1'b0, rst = 1'b0, rxd = 1'b1, bus_gnt = 1'b1;
  logic txd, bus_req, read, busy;
  logic [15:0] address;
  logic [7:0] dout, din = 8'h00, mb, r;
  logic [7:0] rxq[$];
  int checks = 0, failures = 0, wr_cnt = 0, bad;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;

  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .READ_WAIT(1)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .address(address), .dout(dout), .din(din), .read(read), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    case (a)
      16'h0123: mem = 8'h3C;
      16'h0010: mem = 8'h5A;
      16'h0001: mem = 8'h77;
      default:  mem = a[7:0] ^ 8'hFF;
    endcase
  endfunction

  always @(posedge clk) din <= mem(address);

  always @(negedge clk) if (rst && !read) begin
    wr_cnt <= wr_cnt + 1;
    wr_addr <= address;
    wr_data <= dout;
  end

  initial forever begin
    @(negedge clk);
    if (txd === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mb[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      rxq.push_back(mb);
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic get_reply(output logic [7:0] b);
    b = 8'hxx;
    for (int i = 0; i < 3000 && rxq.size() == 0; i++) @(negedge clk);
    if (rxq.size() > 0) b = rxq.pop_front();
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_read", read, 1);
    chk("rst_busy", busy, 0);
    chk("rst_address", address, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send(8'h57); send(8'hE6); send(8'hD0); send(8'hA5);
    get_reply(r);
    chk("wr_reply", r, 8'h2E);
    chk("wr_strobes", wr_cnt, 1);
    chk("wr_addr", wr_addr, 16'hE6D0);
    chk("wr_data", wr_data, 8'hA5);
    chk("wr_bus_req_after", bus_req, 0);
    chk("wr_busy_after", busy, 0);
`ifdef UART_BRIDGE_AUTOINC_EN
    chk("wr_addr_hold", address, 16'hE6D1);
`else
    chk("wr_addr_hold", address, 16'hE6D0);
`endif

    send(8'h52); send(8'h01); send(8'h23);
    get_reply(r);
    chk("rd_reply", r, 8'h3C);
    chk("rd_bus_req_after", bus_req, 0);
    chk("rd_no_strobe", wr_cnt, 1);

    bus_gnt = 1'b0;
    send(8'h52); send(8'h00); send(8'h10);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_req !== 1'b1 || read !== 1'b1) bad++;
    end
    chk("gnt_wait_hold", bad, 0);
    chk("gnt_wait_no_reply", rxq.size(), 0);
    chk("gnt_wait_busy", busy, 1);
    bus_gnt = 1'b1;
    get_reply(r);
    chk("gnt_rd_reply", r, 8'h5A);
    chk("gnt_bus_req_after", bus_req, 0);

    send(8'h41);
    get_reply(r);
    chk("unknown_reply", r, 8'h3F);
    send(8'h57, 1'b0);
    repeat (100) @(negedge clk);
    chk("bad_stop_idle", busy, 0);
    chk("bad_stop_no_reply", rxq.size(), 0);
    rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_idle", busy, 0);
    chk("glitch_no_reply", rxq.size(), 0);
    send(8'h41);
    get_reply(r);
    chk("after_glitch_reply", r, 8'h3F);

`ifdef UART_BRIDGE_AUTOINC_EN
    send(8'h57); send(8'hFF); send(8'hFF); send(8'h11);
    get_reply(r);
    chk("ai_w1_reply", r, 8'h2E);
    chk("ai_w1_addr", wr_addr, 16'hFFFF);
    chk("ai_w1_data", wr_data, 8'h11);
    send(8'h6D); send(8'h22);
    get_reply(r);
    chk("ai_m_reply", r, 8'h2E);
    chk("ai_m_addr", wr_addr, 16'h0000);
    chk("ai_m_data", wr_data, 8'h22);
    send(8'h6E);
    get_reply(r);
    chk("ai_n_reply", r, 8'h77);
    chk("ai_n_addr_next", address, 16'h0002);
`else
    send(8'h6E);
    get_reply(r);
    chk("no_ai_n_reply", r, 8'h3F);
    send(8'h6D);
    get_reply(r);
    chk("no_ai_m_reply", r, 8'h3F);
`endif

    send(8'h41);
    for (int i = 0; i < 2000 && txd !== 1'b0; i++) @(negedge clk);
    chk("tx_started", txd, 0);
    repeat (40) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midtx_rst_txd", txd, 1);
    chk("midtx_rst_bus_req", bus_req, 0);
    chk("midtx_rst_read", read, 1);
    chk("midtx_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    rxq.delete();
    send(8'h41);
    get_reply(r);
    chk("post_rst_reply", r, 8'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
